// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode instruction buffer with in-flight request tracking and flush drop
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        move_fetch,
  output logic [31:0] pc_next,
  input  logic        imem_rqst,
  input  logic [31:0] pc,
  input  logic [63:0] order,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        move_flush,
  output logic        dq_valid,
  output logic [31:0] dq_inst,
  output logic [31:0] dq_pc,
  output logic [63:0] dq_order,
  input  logic        dq_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING + 1);
  logic [31:0] iq_inst_q [DEPTH];
  logic [31:0] iq_pc_q [DEPTH];
  logic [63:0] iq_order_q [DEPTH];
  logic [31:0] pm_pc_q [2**MW];
  logic [63:0] pm_order_q [2**MW];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] ph_q, ph_d, pt_q, pt_d;
  logic [PW-1:0] pend_q, pend_d, drop_q, drop_d;
  logic push_rq, resp_ok, take, pop;
  assign push_rq    = imem_rqst && !move_flush;
  assign resp_ok    = imem_resp && !move_flush;
  assign take       = resp_ok && drop_q == '0;
  assign dq_valid   = !rst && cnt_q != '0;
  assign pop        = dq_valid && dq_ready && !move_flush;
  assign move_fetch = !rst && !move_flush
                      && (32'(pend_q) + 32'(drop_q) < 32'(MAX_OUTSTANDING))
                      && (32'(cnt_q) + 32'(pend_q) < 32'(DEPTH));
  assign pc_next    = pc + 32'd4;
  assign dq_inst    = iq_inst_q[head_q];
  assign dq_pc      = iq_pc_q[head_q];
  assign dq_order   = iq_order_q[head_q];
  // Next-state of pointers and counters; a flush empties both FIFOs and turns pending into drops
  always_comb begin
    head_d = move_flush ? '0 : head_q + AW'(pop);
    tail_d = move_flush ? '0 : tail_q + AW'(take);
    cnt_d  = move_flush ? '0 : cnt_q + CW'(take) - CW'(pop);
    ph_d   = move_flush ? '0 : ph_q + MW'(take);
    pt_d   = move_flush ? '0 : pt_q + MW'(push_rq);
    pend_d = move_flush ? '0 : pend_q + PW'(push_rq) - PW'(take);
    drop_d = move_flush ? drop_q + pend_q - PW'(imem_resp)
                        : drop_q - PW'(resp_ok && drop_q != '0);
  end
  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ph_q   <= '0;
      pt_q   <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      pt_q   <= pt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end
  // FIFO storage writes and fetch/memory protocol checks
  always_ff @(posedge clk) begin
    if (push_rq) begin
      pm_pc_q[pt_q]    <= pc;
      pm_order_q[pt_q] <= order;
    end
    if (take) begin
      iq_inst_q[tail_q]  <= imem_rdata;
      iq_pc_q[tail_q]    <= pm_pc_q[ph_q];
      iq_order_q[tail_q] <= pm_order_q[ph_q];
    end
    if (!rst && imem_rqst) assert (move_fetch);
    if (!rst && imem_resp) assert (pend_q != '0 || drop_q != '0);
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of streaming, backpressure, flush drop and reset
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        move_fetch;
  logic [31:0] pc_next;
  logic        imem_rqst;
  logic [31:0] pc;
  logic [63:0] order;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        move_flush;
  logic        dq_valid;
  logic [31:0] dq_inst;
  logic [31:0] dq_pc;
  logic [63:0] dq_order;
  logic        dq_ready;
  int checks = 0;
  int failures = 0;
  fetch_queue dut (
    .clk(clk), .rst(rst), .move_fetch(move_fetch), .pc_next(pc_next),
    .imem_rqst(imem_rqst), .pc(pc), .order(order), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .move_flush(move_flush), .dq_valid(dq_valid),
    .dq_inst(dq_inst), .dq_pc(dq_pc), .dq_order(dq_order), .dq_ready(dq_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [63:0] o);
    return 32'hC0DE0000 | {16'h0, o[15:0]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rq, input logic [31:0] p, input logic [63:0] o,
                       input logic rs, input logic [31:0] rd, input logic fl, input logic rdy);
    imem_rqst = rq;
    pc = p;
    order = o;
    imem_resp = rs;
    imem_rdata = rd;
    move_flush = fl;
    dq_ready = rdy;
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic head(input logic [31:0] p, input logic [63:0] o);
    check("head_valid", {63'd0, dq_valid}, 64'd1);
    check("head_pc", {32'd0, dq_pc}, {32'd0, p});
    check("head_order", dq_order, o);
    check("head_inst", {32'd0, dq_inst}, {32'd0, ins(o)});
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    check("rst_valid", {63'd0, dq_valid}, 64'd0);
    check("rst_mf", {63'd0, move_fetch}, 64'd0);
    rst = 1'b0;
    // streaming with 1-cycle memory latency
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h60000000 + 32'(i * 4), 64'(i), i > 0, ins(64'(i - 1)), 0, 1);
      check("stream_mf", {63'd0, move_fetch}, 64'd1);
      check("stream_pc_next", {32'd0, pc_next}, {32'd0, 32'h60000004 + 32'(i * 4)});
      tick;
      if (i > 0) head(32'h60000000 + 32'(4 * (i - 1)), 64'(i - 1));
    end
    drive(0, 0, 0, 1, ins(5), 0, 1);
    tick;
    head(32'h60000014, 5);
    drive(0, 32'hFFFFFFFC, 0, 0, 0, 0, 1);
    check("pc_next_wrap", {32'd0, pc_next}, 64'd0);
    tick;
    check("stream_empty", {63'd0, dq_valid}, 64'd0);
    // backpressure: fill all 8 entries
    for (int j = 0; j < 8; j++) begin
      drive(1, 32'h1000 + 32'(4 * j), 64'(100 + j), j > 0, ins(64'(99 + j)), 0, 0);
      check("bp_mf", {63'd0, move_fetch}, 64'd1);
      tick;
    end
    drive(0, 0, 0, 1, ins(107), 0, 0);
    check("bp_mf_limit", {63'd0, move_fetch}, 64'd0);
    tick;
    head(32'h1000, 100);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("bp_full_mf", {63'd0, move_fetch}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    head(32'h1004, 101);
    drive(1, 32'h2000, 200, 0, 0, 0, 0);
    check("bp_refill_mf", {63'd0, move_fetch}, 64'd1);
    tick;
    head(32'h1004, 101);
    drive(0, 0, 0, 1, ins(200), 0, 1);
    check("bp_near_full_mf", {63'd0, move_fetch}, 64'd0);
    tick;
    for (int k = 102; k < 108; k++) begin
      head(32'h1000 + 32'(4 * (k - 100)), 64'(k));
      drive(0, 0, 0, 0, 0, 0, 1);
      tick;
    end
    head(32'h2000, 200);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    check("bp_drained", {63'd0, dq_valid}, 64'd0);
    // flush with 3 outstanding and 2 buffered
    drive(1, 32'h3000, 300, 0, 0, 0, 0);
    tick;
    drive(1, 32'h3004, 301, 1, ins(300), 0, 0);
    tick;
    drive(1, 32'h3008, 302, 1, ins(301), 0, 0);
    tick;
    drive(1, 32'h300C, 303, 0, 0, 0, 0);
    tick;
    drive(1, 32'h3010, 304, 0, 0, 0, 0);
    check("fl_pre_mf", {63'd0, move_fetch}, 64'd1);
    tick;
    drive(0, 0, 0, 0, 0, 1, 1);
    check("fl_mf", {63'd0, move_fetch}, 64'd0);
    check("fl_valid_before", {63'd0, dq_valid}, 64'd1);
    tick;
    check("fl_valid_after", {63'd0, dq_valid}, 64'd0);
    drive(1, 32'h8000, 400, 0, 0, 0, 0);
    check("fl_newpath_mf", {63'd0, move_fetch}, 64'd1);
    tick;
    drive(0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    check("fl_outstanding_mf", {63'd0, move_fetch}, 64'd0);
    tick;
    drive(0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    tick;
    check("fl_drop2", {63'd0, dq_valid}, 64'd0);
    drive(0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    tick;
    check("fl_drop3", {63'd0, dq_valid}, 64'd0);
    drive(0, 0, 0, 1, ins(400), 0, 0);
    tick;
    head(32'h8000, 400);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    check("fl_empty", {63'd0, dq_valid}, 64'd0);
    // flush with a coincident response and 2 pending
    drive(1, 32'h5000, 500, 0, 0, 0, 0);
    tick;
    drive(1, 32'h5004, 501, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
    check("flc_mf", {63'd0, move_fetch}, 64'd0);
    tick;
    check("flc_valid", {63'd0, dq_valid}, 64'd0);
    drive(1, 32'h9000, 600, 0, 0, 0, 0);
    check("flc_newpath_mf", {63'd0, move_fetch}, 64'd1);
    tick;
    drive(0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    tick;
    check("flc_drop", {63'd0, dq_valid}, 64'd0);
    drive(0, 0, 0, 1, ins(600), 0, 0);
    tick;
    head(32'h9000, 600);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    check("flc_empty", {63'd0, dq_valid}, 64'd0);
    // reset mid-operation with 5 buffered and 3 outstanding
    for (int j = 0; j < 8; j++) begin
      drive(1, 32'h4000 + 32'(4 * j), 64'(800 + j), j >= 1 && j <= 5, ins(64'(799 + j)), 0, 0);
      check("rm_mf", {63'd0, move_fetch}, 64'd1);
      tick;
    end
    head(32'h4000, 800);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rm_full_mf", {63'd0, move_fetch}, 64'd0);
    rst = 1'b1;
    tick;
    check("rm_rst_valid", {63'd0, dq_valid}, 64'd0);
    check("rm_rst_mf", {63'd0, move_fetch}, 64'd0);
    rst = 1'b0;
    drive(1, 32'hA000, 700, 0, 0, 0, 0);
    check("rm_post_valid", {63'd0, dq_valid}, 64'd0);
    check("rm_post_mf", {63'd0, move_fetch}, 64'd1);
    tick;
    drive(0, 0, 0, 1, ins(700), 0, 0);
    tick;
    head(32'hA000, 700);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
